// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage. IF/ID and the hazard
// unit also import NOP_INSTR from here.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES          = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & 32'h0000_0003) != 32'h0;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register: load an aligned redirect target, step by one
// instruction, or hold. Load takes priority over increment.
module fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [31:0] load_target,
    input  logic        incr_en,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_four
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;
    logic [31:0] pc_inc;

    // 32-bit add wraps naturally, so 32'hFFFF_FFFC steps to 0.
    assign pc_inc = pc_q + INSTR_BYTES;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = align_word(load_target);
        end else if (incr_en) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus_four = pc_inc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: one outstanding imem request at a time, holds the
// returned word until IF/ID loads it, and discards responses made stale by a redirect.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_INSTR    = instruction_fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetchStall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic [31:0] pcAddress_IF,
    output logic [31:0] instructionCode_IF,
    output logic [31:0] pcPlusFour_IF,
    output logic        fetchValid_IF,
    output logic        fetchMisaligned
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  instr_buf_q;
    logic [31:0]  instr_buf_d;
    logic         pc_incr;
    logic [31:0]  pc;
    logic [31:0]  pc_plus_four;

    fetch_pc_reg #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk          (clk),
        .rst_n        (reset),
        .load_en      (redirectValid),
        .load_target  (redirectTarget),
        .incr_en      (pc_incr),
        .pc           (pc),
        .pc_plus_four (pc_plus_four)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_buf_q <= NOP_INSTR;
        end else begin
            instr_buf_q <= instr_buf_d;
        end
    end

    // Redirect wins over stall and response in every state; the pc load
    // itself happens in fetch_pc_reg whenever redirectValid is high.
    always_comb begin
        state_d     = state_q;
        instr_buf_d = instr_buf_q;
        pc_incr     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!redirectValid && imemReady) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirectValid) begin
                    state_d = imemRespValid ? ST_FETCH : ST_DROP;
                end else if (imemRespValid) begin
                    instr_buf_d = imemRespData;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirectValid) begin
                    state_d = ST_FETCH;
                end else if (!fetchStall) begin
                    pc_incr = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                // A stale response frees the port even if a new redirect
                // lands in the same cycle; otherwise we would wait forever.
                if (imemRespValid) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Gating with reset keeps imemReq and the misalignment pulse low
    // combinationally for the whole time reset is held.
    always_comb begin
        imemReq            = 1'b0;
        fetchValid_IF      = 1'b0;
        instructionCode_IF = NOP_INSTR;
        fetchMisaligned    = 1'b0;
        if (reset) begin
            imemReq         = (state_q == ST_FETCH) && !redirectValid;
            fetchMisaligned = redirectValid && is_misaligned(redirectTarget);
        end
        if ((state_q == ST_HOLD) && !redirectValid) begin
            fetchValid_IF      = 1'b1;
            instructionCode_IF = instr_buf_q;
        end
    end

    assign imemAddr      = pc;
    assign pcAddress_IF  = pc;
    assign pcPlusFour_IF = pc_plus_four;

endmodule
